// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings a PLL out of powerdown, waits for a stable
// synchronized lock, and then releases the PLL clock domain. Lock timeouts
// are retried up to a fixed budget, after which the block parks in FAULT.
//
// Ports:
//   Clock           free-running reference clock (not a PLL output)
//   Reset_N         asynchronous active-low reset
//   Enable          level request to bring the PLL up and keep it up
//   Restart_Req     single-cycle pulse: full power-cycle, clears FAULT
//   PLL_LOCK        raw asynchronous lock indication from the PLL
//   PLL_POWERDOWN_N PLL powerdown pin (0 = powered down)
//   Clk_Ready       PLL outputs valid and stable
//   Domain_Reset_N  reset for logic clocked by the PLL outputs
//   Lock_Lost       one-cycle pulse when lock drops while RUNNING
//   Fault           retry budget exhausted
//   Retry_Count     lock timeouts since the last RUNNING or Restart_Req
//   Lost_Count      lock-loss events, saturating at 255
//   State           current state encoding
module pll_lock_sequencer #(
    parameter int unsigned PD_HOLD      = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned STABLE_CNT   = 256,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       Clock,
    input  logic       Reset_N,
    input  logic       Enable,
    input  logic       Restart_Req,
    input  logic       PLL_LOCK,
    output logic       PLL_POWERDOWN_N,
    output logic       Clk_Ready,
    output logic       Domain_Reset_N,
    output logic       Lock_Lost,
    output logic       Fault,
    output logic [3:0] Retry_Count,
    output logic [7:0] Lost_Count,
    output logic [2:0] State
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PD    = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STAB  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam int unsigned MAX_A   = (PD_HOLD > LOCK_TIMEOUT) ? PD_HOLD : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_A > STABLE_CNT) ? MAX_A : STABLE_CNT;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [1:0]       sync_q;
    logic             lock_s;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             lost_evt;

    assign lock_s = sync_q[1];
    assign State  = state;

    // Two-flop synchronizer for the asynchronous lock input
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], PLL_LOCK};
    end

    // State register
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state, counter and retry logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        retry_nxt = Retry_Count;
        lost_evt  = 1'b0;

        if (!Enable) begin
            state_nxt = S_IDLE;
        end else if (Restart_Req) begin
            state_nxt = S_PD;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_PD;
                S_PD: begin
                    if (cnt == CNT_W'(PD_HOLD - 1)) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_nxt = S_STAB;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        // Clamp so a count left over from an earlier FAULT cannot overrun the budget
                        if (Retry_Count >= 4'(MAX_RETRY - 1)) begin
                            retry_nxt = 4'(MAX_RETRY);
                            state_nxt = S_FAULT;
                        end else begin
                            retry_nxt = Retry_Count + 4'd1;
                            state_nxt = S_PD;
                        end
                    end
                end
                S_STAB: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT;
                    end else if (cnt == CNT_W'(STABLE_CNT - 1)) begin
                        state_nxt = S_RUN;
                        retry_nxt = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        lost_evt  = 1'b1;
                        state_nxt = S_PD;
                    end
                end
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_IDLE;
            endcase
        end

        // A restart re-enters POWERDOWN from POWERDOWN, so it clears the count explicitly
        if ((state_nxt != state) || (Enable && Restart_Req)) cnt_nxt = '0;
    end

    // Counter, status and outputs; outputs follow the next state so they line up with State
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            cnt             <= '0;
            Retry_Count     <= 4'd0;
            Lost_Count      <= 8'd0;
            PLL_POWERDOWN_N <= 1'b0;
            Clk_Ready       <= 1'b0;
            Domain_Reset_N  <= 1'b0;
            Lock_Lost       <= 1'b0;
            Fault           <= 1'b0;
        end else begin
            cnt             <= cnt_nxt;
            Retry_Count     <= retry_nxt;
            PLL_POWERDOWN_N <= (state_nxt == S_WAIT) || (state_nxt == S_STAB) ||
                               (state_nxt == S_RUN);
            Clk_Ready       <= (state_nxt == S_RUN);
            Domain_Reset_N  <= (state_nxt == S_RUN);
            Lock_Lost       <= lost_evt;
            Fault           <= (state_nxt == S_FAULT);
            if (lost_evt && (Lost_Count != 8'hFF)) Lost_Count <= Lost_Count + 8'd1;
        end
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- PD_HOLD, 16: cycles PLL_POWERDOWN_N is held low on every (re)start.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry.
- STABLE_CNT, 256: consecutive synchronized-lock cycles required before RUNNING.
- MAX_RETRY, 3: lock timeouts tolerated before FAULT; range 1-15.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- Clock, in, 1: free-running reference-domain clock, not a PLL output.
- Reset_N, in, 1: asynchronous active-low reset.
- Enable, in, 1: level; 1 = bring the PLL up and keep it up.
- Restart_Req, in, 1: single-cycle pulse; forces a full power-cycle, and clears FAULT.
- PLL_LOCK, in, 1: raw asynchronous lock from the PLL.
- PLL_POWERDOWN_N, out, 1: drives the PLL powerdown pin.
- Clk_Ready, out, 1: PLL outputs valid and stable.
- Domain_Reset_N, out, 1: reset for logic clocked by the PLL outputs.
- Lock_Lost, out, 1: one-cycle pulse when lock drops in RUNNING.
- Fault, out, 1: retry budget exhausted.
- Retry_Count, out, 4: lock timeouts since the last RUNNING or Restart_Req.
- Lost_Count, out, 8: lock-loss events, saturating at 255.
- State, out, 3: current state encoding.

Function
REQ-004 PLL_LOCK SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s, so there is 2 cycles of latency from PLL_LOCK.
REQ-005 The state encodings SHALL be: IDLE=0, POWERDOWN=1, WAIT_LOCK=2, STABILIZE=3, RUNNING=4, FAULT=5. Values 6-7 SHALL recover to IDLE.
REQ-006 Transition priority SHALL be evaluated every cycle, highest first:
- Enable=0 -> IDLE.
- Restart_Req=1 -> POWERDOWN, with Retry_Count cleared and Fault cleared.
- The per-state rules below.
REQ-007 IDLE: PLL_POWERDOWN_N=0; Enable=1 -> POWERDOWN.
REQ-008 POWERDOWN: PLL_POWERDOWN_N=0 for exactly PD_HOLD cycles, then -> WAIT_LOCK with the cycle counter cleared.
REQ-009 WAIT_LOCK: PLL_POWERDOWN_N=1.
- lock_s=1 -> STABILIZE.
- Counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> Retry_Count+1, then:
  - if the new count equals MAX_RETRY -> FAULT;
  - otherwise -> POWERDOWN.
REQ-010 STABILIZE: PLL_POWERDOWN_N=1.
- lock_s must hold 1 for STABLE_CNT consecutive cycles, then -> RUNNING and Retry_Count cleared.
- lock_s=0 at any point -> WAIT_LOCK with the counter restarted; no retry increment.
REQ-011 RUNNING: PLL_POWERDOWN_N=1, Clk_Ready=1, Domain_Reset_N=1.
- lock_s=0 -> Lock_Lost pulses for 1 cycle, Lost_Count increments (saturating), and the state goes -> POWERDOWN.
REQ-012 FAULT: PLL_POWERDOWN_N=0 and Fault=1.
- Exits only via Enable=0 (-> IDLE, Fault cleared) or Restart_Req.
- Retry_Count holds MAX_RETRY while in FAULT.
REQ-013 All outputs SHALL be registered.
- Clk_Ready and Domain_Reset_N assert on the first cycle State=4 and deassert on the cycle State leaves 4.
- Domain_Reset_N=0 in every state other than RUNNING.
REQ-014 The single cycle counter SHALL be shared between states, cleared on every state change, and no wider than needed for max(PD_HOLD, LOCK_TIMEOUT, STABLE_CNT).
REQ-015 Restart_Req while in POWERDOWN SHALL restart the PD_HOLD count.

Reset
REQ-016 While Reset_N=0 the block SHALL hold these values:
- State=IDLE, PLL_POWERDOWN_N=0, Clk_Ready=0, Domain_Reset_N=0.
- Lock_Lost=0, Fault=0, Retry_Count=0, Lost_Count=0.
- Synchronizer flops=0.
REQ-017 Reset assertion mid-operation SHALL force these values immediately (asynchronously); after release the block SHALL start from IDLE.

Verification
Benches use PD_HOLD=4, LOCK_TIMEOUT=16, STABLE_CNT=8, MAX_RETRY=3.
REQ-018 Normal bring-up: Enable=1, PLL_LOCK rising 5 cycles after PLL_POWERDOWN_N rises -> PLL_POWERDOWN_N low for exactly 4 cycles; State=4 and Clk_Ready=1 exactly 2+8 cycles after PLL_LOCK rises (+1 transition cycle); Retry_Count=0.
REQ-019 Lock never arrives -> 3 power-down/WAIT_LOCK cycles of 4+16 cycles each, then Fault=1, State=5, Retry_Count=3, PLL_POWERDOWN_N=0 held indefinitely.
REQ-020 Lock glitch in STABILIZE: PLL_LOCK low for 1 cycle after 5 stable cycles -> return to WAIT_LOCK; the full 8-cycle stable window restarts; no retry increment.
REQ-021 Lock loss in RUNNING -> one Lock_Lost pulse, Lost_Count=1, Clk_Ready and Domain_Reset_N drop the same cycle State leaves 4, automatic re-lock succeeds; test Lost_Count saturation at 255.
REQ-022 Simultaneous Enable=0 and Restart_Req=1 in FAULT -> IDLE, Fault=0; a Reset_N pulse in RUNNING -> all outputs reach their reset values without any clock edge.
